irq_controller: RTL
===================

# irq_controller

Interrupt controller feeding the CPU's `IRQ` and `IC[3:0]` inputs. It synchronises 16 external request lines, latches rising edges as pending, and picks the highest-priority enabled source. It presents that source's vector to the CPU and holds it until software acknowledges it and signals end-of-interrupt. The block sits on the CPU's address/data bus as a 4-word memory-mapped peripheral.

## Interface
- `BASE_ADDR`, default 16'hFF00: base of the 4-word register window; must be 4-aligned (`BASE_ADDR[1:0]` = 0).
- `CLK` input 1: system clock; all state changes on the rising edge.
- `RST` input 1: reset, synchronous and active-high.
- `REQ` input 16: interrupt request lines, level, asynchronous to `CLK`; bit 0 is highest priority.
- `A` input 16: CPU address bus.
- `W` input 1: CPU write strobe; 1 = write cycle, 0 = read cycle.
- `D` inout 16: CPU data bus; driven only during a read of the window, otherwise high-Z.
- `IRQ` output 1: interrupt request to the CPU.
- `IC` output 4: vector (source index) of the requesting or in-service interrupt.

## Operation
- **Window select:** `A[15:2] == BASE_ADDR[15:2]`. The offset is `A[1:0]`.
- **Register map:**
  - +0 PENDING: read returns the 16-bit pending register. Write is write-1-to-clear.
  - +1 MASK: read/write, 16 bits. Bit = 1 enables the source. Reset value 0x0000 (all disabled).
  - +2 VECTOR: read returns {12'b0, IC}. Write = ACK; data ignored.
  - +3 STATUS: read returns {14'b0, state}, with IDLE=0, ASSERT=1, INSERVICE=2. Write = EOI; data ignored.
- **Reads:** `D` is driven combinationally while the window is selected and `W`=0. Otherwise `D` = 16'hzzzz.
- **Writes:** take effect at the `CLK` edge where the window is selected and `W`=1.
- **Input path:**
  - Two-flop synchroniser per line: `s1 <= REQ`, `s2 <= s1`.
  - Edge detect: pending bit i sets when `s1[i] & ~s2[i]`.
  - A level held high sets pending only once.
- **Same-cycle set and clear:** if a set and a W1C clear hit the same bit in the same cycle, the set wins.
- **State machine:**
  - IDLE: `IRQ`=0. If `(PENDING & MASK) != 0`, latch the lowest set index into `IC` and go to ASSERT at that edge.
  - ASSERT: `IRQ`=1, `IC` held.
    - On ACK: clear `PENDING[IC]` and go to INSERVICE.
    - If the source's MASK bit reads 0 (masked after selection) and no ACK occurs that cycle: go to IDLE; `PENDING[IC]` is retained.
    - ACK has priority over a same-cycle mask change.
  - INSERVICE: `IRQ`=0, `IC` held, no nesting. On EOI, go to IDLE.
  - ACK outside ASSERT and EOI outside INSERVICE are ignored.
- **Priority:** re-evaluated only in IDLE. A higher-priority source arriving during ASSERT does not preempt the selected source.
- **`IRQ` and `IC`:** both are registered outputs decoded from state. No combinational path from `REQ` or the bus to `IRQ`/`IC`.

## Timing
- **Reset:** `RST`=1 at an edge clears `s1`, `s2`, PENDING, MASK and `IC` to 0 and sets state to IDLE. After that edge `IRQ`=0, `IC`=0 and `D`=high-Z (unless a read is selected). Reset overrides any bus write in the same cycle and aborts ASSERT or INSERVICE immediately.
- **Request latency,** with `REQ[i]` rising before edge k, source enabled, state IDLE:
  - edge k: `s1` = 1.
  - edge k+1: PENDING[i] = 1.
  - edge k+2: state = ASSERT; `IRQ`=1 and `IC`=i visible after this edge.
- **ACK:** a write to +2 at edge m gives `IRQ`=0 after edge m, and PENDING[IC] reads 0 from then on.
- **EOI and re-assert:** EOI at edge n gives state IDLE after edge n. If another enabled source is pending, `IRQ` re-asserts after edge n+1. Minimum `IRQ` low time between interrupts is therefore 1 cycle after EOI.
- **Re-trigger:** a source re-triggered while INSERVICE sets its PENDING bit again. It is serviced after EOI.
- **Reads:** read data reflects register state as of the last edge (no bypass of same-cycle writes).

## Test plan
- **Reset mid-operation:** drive `REQ[3]` high, MASK=0x0008, get to ASSERT, then pulse `RST` for one cycle. Required after that edge: `IRQ`=0, `IC`=0, PENDING=0x0000, MASK=0x0000. `REQ[3]` still high must not re-pend (after 3+ cycles PENDING stays 0).
- **Basic flow:** MASK=0xFFFF, raise `REQ[5]` before edge k. Required: `IRQ`=1, `IC`=5 after edge k+2. Write +2 → `IRQ`=0, STATUS=2, PENDING=0x0000. Write +3 → STATUS=0.
- **Priority:** with state INSERVICE, raise `REQ[9]` and `REQ[2]` in the same cycle, then EOI. Required: `IC`=2 asserted first. After ACK+EOI, `IC`=9 asserted, with `IRQ` re-asserting 1 cycle after EOI.
- **Masking:** PENDING=0x0010, MASK=0x0000 → `IRQ` stays 0 for 10 cycles. Write MASK=0x0010 → `IRQ`=1 two edges later. Then write MASK=0 while in ASSERT → `IRQ`=0 after the next edge, PENDING still 0x0010.
- **W1C vs set:** write 0x0001 to +0 in the same cycle pending bit 0 is being set by an edge. Required: PENDING[0]=1. A write of 0xFFFF with no edge clears all bits to 0x0000.
- **Bus hygiene:** reads at `BASE_ADDR`+0..3 return the documented values. Required: `D`=high-Z when `A`=`BASE_ADDR`+4 or `W`=1. ACK issued in IDLE and EOI issued in ASSERT leave the state unchanged.

Source files
------------

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - 16-source priority interrupt controller with a 4-word bus window
module irq_controller #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] REQ,
  input  logic [15:0] A,
  input  logic        W,
  inout  wire  [15:0] D,
  output logic        IRQ,
  output logic [3:0]  IC
);

  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, INSERVICE = 2'd2} state_e;

  state_e      state_q, state_d;
  logic [15:0] s1_q, s1_d, s2_q, s2_d;
  logic [15:0] arm_q, arm_d, pend_q, pend_d, mask_q, mask_d;
  logic        valid_q, valid_d;
  logic [3:0]  ic_q, ic_d;
  logic        sel, wr, rd, ack, eoi;
  logic [15:0] rise, active, rdata;
  logic [3:0]  first_idx;

  assign sel    = (A[15:2] == BASE_ADDR[15:2]);
  assign wr     = sel & W;
  assign rd     = sel & ~W;
  assign ack    = wr & (A[1:0] == 2'd2);
  assign eoi    = wr & (A[1:0] == 2'd3);
  assign active = pend_q & mask_q;

  always_comb begin
    first_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (active[i]) first_idx = 4'(i);
    end
  end

  // A line only arms once it has been seen low after reset, so a level held across reset never pends.
  always_comb begin
    s1_d    = REQ;
    s2_d    = s1_q;
    valid_d = 1'b1;
    arm_d   = arm_q | (~s1_q & {16{valid_q}});
    rise    = s1_q & ~s2_q & arm_q;
    mask_d  = (wr && A[1:0] == 2'd1) ? D : mask_q;
    pend_d  = pend_q;
    if (wr && A[1:0] == 2'd0) pend_d = pend_d & ~D;
    if (state_q == ASSERT && ack) pend_d[ic_q] = 1'b0;
    pend_d = pend_d | rise;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      arm_q   <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      mask_q  <= '0;
      ic_q    <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      arm_q   <= arm_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      ic_q    <= ic_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ic_d    = ic_q;
    case (state_q)
      IDLE: begin
        if (active != 16'h0000) begin
          state_d = ASSERT;
          ic_d    = first_idx;
        end
      end
      ASSERT: begin
        if (ack)                 state_d = INSERVICE;
        else if (!mask_q[ic_q])  state_d = IDLE;
      end
      INSERVICE: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    IRQ = (state_q == ASSERT);
    IC  = ic_q;
  end

  always_comb begin
    case (A[1:0])
      2'd0:    rdata = pend_q;
      2'd1:    rdata = mask_q;
      2'd2:    rdata = {12'b0, ic_q};
      default: rdata = {14'b0, state_q};
    endcase
  end

  assign D = rd ? rdata : 16'hzzzz;

endmodule
